// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit/receive pair: the frame state
// encoding, frame geometry constants and the baud divisor helper.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    ACK
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  // Clock cycles per serial bit (integer divide, remainder discarded).
  function automatic int baud_cycles(input int clk_frequency, input int baud_rate);
    return clk_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/baud_timer.sv
// -----------------------------------------------------------------------------
// baud_timer
// Free-running bit-period counter. Counts 0..BAUD_CYCLES-1 and wraps.
//   clk  : system clock
//   rst  : asynchronous active-high reset, counter to 0
//   clr  : hold the counter at 0 (used while no bit is being timed)
//   done : high on the last cycle of a bit period
// -----------------------------------------------------------------------------
module baud_timer #(
  parameter int BAUD_CYCLES = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic done
);

  localparam int TW = (BAUD_CYCLES > 1) ? $clog2(BAUD_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(BAUD_CYCLES - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: one byte per Send/Sent four-phase handshake, sent as
// start(0), 8 data bits LSB first, parity, stop(1). Each bit lasts
// CLK_FREQUENCY/BAUD_RATE clocks.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   Send : request, held high until Sent is seen
//   Din  : byte to send, sampled on the accept cycle only
//   Sent : frame complete, held high until Send drops
//   Sout : serial line (registered, idles high)
//   Busy : high from the accept cycle through the end of the stop bit
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int PARITY_ODD    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Send,
  input  logic [7:0] Din,
  output logic       Sent,
  output logic       Sout,
  output logic       Busy
);

  localparam int BAUD_CYCLES = baud_cycles(CLK_FREQUENCY, BAUD_RATE);

  uart_state_e state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        sout_q, sout_d;
  logic        sent_q, sent_d;
  logic        busy_q, busy_d;
  logic [7:0]  shift_q;
  logic        par_q;
  logic        accept;
  logic        shift_en;
  logic        bit_done;
  logic        timer_clr;

  // The timer only runs while a bit is on the line, so it starts every
  // frame from 0 on the first start-bit cycle.
  assign timer_clr = (state_q == IDLE) || (state_q == ACK);

  baud_timer #(
    .BAUD_CYCLES(BAUD_CYCLES)
  ) u_baud_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (timer_clr),
    .done (bit_done)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sout_d   = sout_q;
    sent_d   = sent_q;
    busy_d   = busy_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (Send) begin
          accept  = 1'b1;
          state_d = START;
          sout_d  = 1'b0;
          busy_d  = 1'b1;
          idx_d   = 3'd0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          sout_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == 3'd7) begin
            state_d = PARITY;
            sout_d  = par_q;
          end else begin
            // shift_q[0] is the bit now on the line; the next one sits above it.
            shift_en = 1'b1;
            idx_d    = idx_q + 3'd1;
            sout_d   = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
          sout_d  = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = ACK;
          sent_d  = 1'b1;
          busy_d  = 1'b0;
          sout_d  = 1'b1;
        end
      end
      ACK: begin
        if (!Send) begin
          state_d = IDLE;
          sent_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        sout_d  = 1'b1;
        sent_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      sout_q  <= 1'b1;
      sent_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sout_q  <= sout_d;
      sent_q  <= sent_d;
      busy_q  <= busy_d;
    end
  end

  // Frame payload; only meaningful between accept and the parity bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_q <= Din;
      par_q   <= (PARITY_ODD != 0) ? ~^Din : ^Din;
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[7:1]};
    end
  end

  assign Sout = sout_q;
  assign Sent = sent_q;
  assign Busy = busy_q;

endmodule
